// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative multiply/divide unit that owns the HI/LO register pair.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_kill,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int             c_cnt_w     = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  // Operation kind as carried through CALC/FIX (op[2:1] of the arithmetic codes)
  localparam logic [1:0] c_kind_mul  = 2'b00;
  localparam logic [1:0] c_kind_div  = 2'b01;
  localparam logic [1:0] c_kind_madd = 2'b10;
  localparam logic [1:0] c_kind_msub = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [2*WIDTH-1:0]     r_p;
  logic [WIDTH-1:0]       r_mc;
  logic [WIDTH-1:0]       r_a_raw;
  logic [1:0]             r_kind;
  logic                   r_neg_q;
  logic                   r_neg_r;
  logic                   r_dz;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;
  logic                   r_done;

  logic                   w_is_arith;
  logic                   w_is_mt;
  logic                   w_accept;
  logic                   w_mt;
  logic                   w_commit;

  logic                   w_signed;
  logic                   w_a_neg;
  logic                   w_b_neg;
  logic [WIDTH-1:0]       w_a_mag;
  logic [WIDTH-1:0]       w_b_mag;
  logic                   w_op_div;

  logic [WIDTH:0]         w_msum;
  logic [2*WIDTH-1:0]     w_mul_next;
  logic [WIDTH:0]         w_shrem;
  logic                   w_ge;
  logic [WIDTH-1:0]       w_drem;
  logic [2*WIDTH-1:0]     w_div_next;

  logic [2*WIDTH-1:0]     w_prod;
  logic [2*WIDTH-1:0]     w_hilo;
  logic [2*WIDTH-1:0]     w_acc;
  logic [WIDTH-1:0]       w_quo;
  logic [WIDTH-1:0]       w_rem;
  logic [2*WIDTH-1:0]     w_div_res;
  logic [2*WIDTH-1:0]     w_result;

  assign w_is_arith = ~i_op[3];
  assign w_is_mt    = (i_op[3:1] == 3'b100);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_mt     = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && w_is_arith) begin
          w_accept = 1'b1;
          w_next   = S_CALC;
        end else if (i_start && w_is_mt) begin
          w_mt = 1'b1;
        end
      end
      S_CALC: begin
        if (i_kill) begin
          w_next = S_IDLE;
        end else if (r_cnt == c_last_step) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next   = S_IDLE;
        w_commit = ~i_kill;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand capture: signed ops are reduced to magnitudes for the unsigned core
  // --------------------------------------------------------------------------
  assign w_signed = ~i_op[0];
  assign w_a_neg  = w_signed & i_a[WIDTH-1];
  assign w_b_neg  = w_signed & i_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;
  assign w_op_div = (i_op[2:1] == c_kind_div);

  // Shift-add multiply step: multiplier sits in the low half and drains out LSB first
  assign w_msum     = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_mc} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_msum, r_p[WIDTH-1:1]};

  // Restoring divide step: partial remainder stays below the divisor, so WIDTH bits suffice
  assign w_shrem    = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_ge       = (w_shrem >= {1'b0, r_mc});
  assign w_drem     = w_ge ? (w_shrem[WIDTH-1:0] - r_mc) : w_shrem[WIDTH-1:0];
  assign w_div_next = {w_drem, r_p[WIDTH-2:0], w_ge};

  // --------------------------------------------------------------------------
  // FIX: sign correction, accumulation and special divide cases
  // --------------------------------------------------------------------------
  assign w_hilo = {r_hi, r_lo};
  assign w_prod = r_neg_q ? -r_p : r_p;

  always_comb begin
    w_acc = w_prod;
    case (r_kind)
      c_kind_madd: w_acc = w_hilo + w_prod;
      c_kind_msub: w_acc = w_hilo - w_prod;
      default:     w_acc = w_prod;
    endcase
  end

  assign w_quo     = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_rem     = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
  assign w_div_res = r_dz ? {r_a_raw, {WIDTH{1'b1}}} : {w_rem, w_quo};
  assign w_result  = (r_kind == c_kind_div) ? w_div_res : w_acc;

  // --------------------------------------------------------------------------
  // Datapath and architectural registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_p     <= '0;
      r_mc    <= '0;
      r_a_raw <= '0;
      r_kind  <= c_kind_mul;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_mt | w_commit;
      if (w_accept) begin
        r_cnt   <= '0;
        r_kind  <= i_op[2:1];
        r_a_raw <= i_a;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_dz    <= (i_b == '0);
        r_mc    <= w_op_div ? w_b_mag : w_a_mag;
        r_p     <= {{WIDTH{1'b0}}, (w_op_div ? w_a_mag : w_b_mag)};
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + c_cnt_one;
        r_p   <= (r_kind == c_kind_div) ? w_div_next : w_mul_next;
      end
      if (w_mt) begin
        if (i_op[0]) begin
          r_lo <= i_a;
        end else begin
          r_hi <= i_a;
        end
      end
      if (w_commit) begin
        r_hi <= w_result[2*WIDTH-1:WIDTH];
        r_lo <= w_result[WIDTH-1:0];
      end
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed + randomized self-checking bench for muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         i_start;
  logic [3:0]   i_op;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_kill;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_hi;
  logic [W-1:0] o_lo;

  int           errors;
  int           checks;
  logic [63:0]  exp_hl;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_kill  (i_kill),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_hi    (o_hi),
    .o_lo    (o_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the architectural rules
  function automatic logic [63:0] mdl(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [63:0] hl);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = hl;
    case (op)
      4'd0: r = sa * sb;
      4'd1: r = ua * ub;
      4'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      4'd3: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          r  = {ur[31:0], uq[31:0]};
        end
      end
      4'd4: r = hl + sa * sb;
      4'd5: r = hl + ua * ub;
      4'd6: r = hl - sa * sb;
      4'd7: r = hl - ua * ub;
      default: r = hl;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic wait_done(output int lat, output int nbusy, output bit seen);
    lat   = 0;
    nbusy = 0;
    seen  = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (o_done) begin
        lat  = n;
        seen = 1'b1;
        break;
      end
      if (o_busy) nbusy++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit k);
    int lat, nb;
    bit seen;
    exp_hl = mdl(op, a, b, exp_hl);
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_a = a; i_b = b; i_kill = k;
    @(posedge clk);
    #1;
    i_start = 1'b0; i_kill = 1'b0; i_a = $urandom; i_b = $urandom;
    wait_done(lat, nb, seen);
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, " latency"}, 64'(lat), 64'(W + 2));
      check({tag, " busy_cycles"}, 64'(nb), 64'(W + 1));
      check({tag, " busy_at_done"}, 64'(o_busy), 64'd0);
      check({tag, " hilo"}, {o_hi, o_lo}, exp_hl);
      @(negedge clk);
      check({tag, " done_one_cycle"}, 64'(o_done), 64'd0);
    end
  endtask

  task automatic mt(input bit lo_sel, input logic [31:0] v);
    @(negedge clk);
    i_start = 1'b1; i_op = lo_sel ? 4'b1001 : 4'b1000; i_a = v;
    if (lo_sel) exp_hl[31:0] = v; else exp_hl[63:32] = v;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    check("mt hilo_at_edge", {o_hi, o_lo}, exp_hl);
    check("mt busy", 64'(o_busy), 64'd0);
    @(negedge clk);
    check("mt done", 64'(o_done), 64'd1);
    check("mt busy_done_cycle", 64'(o_busy), 64'd0);
    @(negedge clk);
    check("mt done_drop", 64'(o_done), 64'd0);
  endtask

  task automatic no_done_window(input string tag, input int n);
    int dcnt, bcnt;
    dcnt = 0; bcnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_done) dcnt++;
      if (o_busy) bcnt++;
    end
    check({tag, " no_done"}, 64'(dcnt), 64'd0);
    check({tag, " no_busy"}, 64'(bcnt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb;
    bit seen;
    errors = 0; checks = 0;
    rst = 1'b0; i_start = 1'b0; i_op = 4'd0; i_a = '0; i_b = '0; i_kill = 1'b0;
    exp_hl = 64'd0;

    // Reset with start asserted must still land in a clean idle state
    repeat (3) @(posedge clk);
    i_start = 1'b1; i_op = 4'd0;
    @(posedge clk);
    #1;
    i_start = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("reset busy", 64'(o_busy), 64'd0);
    check("reset done", 64'(o_done), 64'd0);
    check("reset hilo", {o_hi, o_lo}, 64'd0);

    run_op("MULT -3*7", 4'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("MULT -3*7 const", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("MULTU max*max", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("MULTU const", {o_hi, o_lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("DIV -7/2", 4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("DIV -7/2 const", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("DIVU 100/7", 4'd3, 32'd100, 32'd7, 1'b0);
    check("DIVU const", {o_hi, o_lo}, {32'd2, 32'd14});
    run_op("DIV 5/0", 4'd2, 32'd5, 32'd0, 1'b0);
    check("DIV0 const", {o_hi, o_lo}, {32'd5, 32'hFFFF_FFFF});
    run_op("DIV ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("DIV ovf const", {o_hi, o_lo}, {32'd0, 32'h8000_0000});

    mt(1'b0, 32'd0);
    mt(1'b1, 32'hFFFF_FFFF);
    run_op("MADDU 1*1", 4'd5, 32'd1, 32'd1, 1'b0);
    check("MADDU const", {o_hi, o_lo}, {32'd1, 32'd0});
    run_op("MSUB 1*1", 4'd6, 32'd1, 32'd1, 1'b0);
    check("MSUB const", {o_hi, o_lo}, {32'd0, 32'hFFFF_FFFF});

    // kill together with start in IDLE: start wins
    run_op("MULTU kill@start", 4'd1, 32'd12345, 32'd678, 1'b1);

    // start held high through the op; operands change after acceptance
    @(negedge clk);
    i_start = 1'b1; i_op = 4'd0; i_a = 32'd2; i_b = 32'd3;
    @(posedge clk);
    #1;
    i_a = 32'd5; i_b = 32'd7;
    wait_done(lat, nb, seen);
    check("hold done_seen", 64'(seen), 64'd1);
    check("hold latency", 64'(lat), 64'(W + 2));
    check("hold hilo", {o_hi, o_lo}, {32'd0, 32'd6});
    @(negedge clk);
    check("hold reaccept busy", 64'(o_busy), 64'd1);
    check("hold reaccept done", 64'(o_done), 64'd0);
    i_start = 1'b0;
    wait_done(lat, nb, seen);
    check("hold2 latency", 64'(lat), 64'(W + 1));
    check("hold2 hilo", {o_hi, o_lo}, {32'd0, 32'd35});
    exp_hl = {32'd0, 32'd35};

    // kill mid-CALC
    mt(1'b0, 32'h11);
    mt(1'b1, 32'h22);
    @(negedge clk);
    i_start = 1'b1; i_op = 4'd3; i_a = 32'd1000; i_b = 32'd7;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    i_kill = 1'b1;
    @(posedge clk);
    #1;
    i_kill = 1'b0;
    check("kill busy_drop", 64'(o_busy), 64'd0);
    no_done_window("kill", 40);
    check("kill hilo", {o_hi, o_lo}, {32'h11, 32'h22});

    // reset mid-CALC
    @(negedge clk);
    i_start = 1'b1; i_op = 4'd3; i_a = 32'd1000; i_b = 32'd7;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_hl = 64'd0;
    check("rst busy", 64'(o_busy), 64'd0);
    check("rst hilo", {o_hi, o_lo}, 64'd0);
    no_done_window("rst", 40);

    // illegal opcodes are ignored
    mt(1'b0, 32'hA5A5_0001);
    mt(1'b1, 32'h5A5A_0002);
    @(negedge clk);
    i_start = 1'b1; i_op = 4'b1111; i_a = 32'd9; i_b = 32'd9;
    @(posedge clk);
    #1;
    i_op = 4'b1010;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    no_done_window("illegal", 6);
    check("illegal hilo", {o_hi, o_lo}, exp_hl);

    // randomized mix against the reference model
    for (int i = 0; i < 30; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel >= 8) mt(sel == 9, pick());
      else run_op("rand", 4'(sel), pick(), pick(), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
